// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: memory busywait freeze, load-use bubbles,
// branch redirects and a watchdog on multi-cycle EX ops. PIPE_CTRL_PERF_EN adds perf counters.
module pipeline_hazard_controller #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        imem_busywait_i,
    input  logic        dmem_busywait_i,
    input  logic        load_stall_i,
    input  logic        branch_taken_ex_i,
    input  logic        mc_start_i,
    input  logic        mc_done_i,
    output logic        freeze_o,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        flush_if_id_o,
    output logic        flush_id_ex_o,
    output logic        redirect_o,
    output logic        mc_abort_o,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_count_o,
`endif
    output logic        state_o
);

    typedef enum logic {RUN = 1'b0, MC_WAIT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(MC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] WD_ONE  = CNT_W'(1);

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   wd_r, wd_s;
    logic               pend_r, pend_s;
    logic               freeze_s, br_s, stall_s, flush_s, abort_s;

    // Hazard priority: freeze > branch redirect > load-use bubble; plus FSM next state.
    always_comb begin
        freeze_s = imem_busywait_i | dmem_busywait_i | ((state_r == MC_WAIT) & ~mc_done_i);
        br_s     = branch_taken_ex_i | pend_r;
        stall_s  = 1'b0;
        flush_s  = 1'b0;
        abort_s  = 1'b0;
        pend_s   = pend_r;
        state_s  = state_r;
        wd_s     = wd_r;

        if (freeze_s) begin
            // A redirect seen while frozen is remembered until the pipe can move.
            pend_s = pend_r | branch_taken_ex_i;
        end else if (br_s) begin
            flush_s = 1'b1;
            pend_s  = 1'b0;
        end else if (load_stall_i) begin
            stall_s = 1'b1;
        end else begin
            stall_s = 1'b0;
        end

        case (state_r)
            RUN: begin
                wd_s = '0;
                if (mc_start_i && !freeze_s && !br_s) begin
                    state_s = MC_WAIT;
                end else begin
                    state_s = RUN;
                end
            end
            MC_WAIT: begin
                if (mc_done_i) begin
                    state_s = RUN;
                    wd_s    = '0;
                end else if (wd_r == WD_LAST) begin
                    abort_s = 1'b1;
                    state_s = RUN;
                    wd_s    = '0;
                end else begin
                    wd_s = wd_r + WD_ONE;
                end
            end
            default: begin
                state_s = RUN;
                wd_s    = '0;
            end
        endcase
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= RUN;
            wd_r    <= '0;
            pend_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            wd_r    <= wd_s;
            pend_r  <= pend_s;
        end
    end

    assign freeze_o      = freeze_s;
    assign stall_if_o    = stall_s;
    assign stall_id_o    = stall_s;
    assign flush_if_id_o = flush_s;
    assign flush_id_ex_o = flush_s;
    assign redirect_o    = flush_s;
    assign mc_abort_o    = abort_s;
    assign state_o       = state_r;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_r, flush_cnt_r;

    // Free-running perf counters, wrapping naturally at 2^32.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_r <= 32'd0;
            flush_cnt_r <= 32'd0;
        end else begin
            stall_cnt_r <= stall_cnt_r + {31'd0, (freeze_s | stall_s)};
            flush_cnt_r <= flush_cnt_r + {31'd0, flush_s};
        end
    end

    assign stall_cycles_o = stall_cnt_r;
    assign flush_count_o  = flush_cnt_r;
`endif

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Combines load-use stall requests from the hazard detection unit, instruction/data memory busywait, taken-branch/jump redirects from EX, and multi-cycle EX operations (mul/div). Produces per-stage freeze, stall and flush controls consumed by the IF, ID and EX pipeline registers.

Parameters:
MC_TIMEOUT, 64, max cycles a multi-cycle EX op may hold the pipe before forced abort (≥2)
CNT_W, 7, width of multi-cycle watchdog counter (must hold MC_TIMEOUT-1)

Ports:
clk_i  input  1  clock, all state on rising edge
rst_ni  input  1  asynchronous active-low reset
imem_busywait_i  input  1  instruction memory not ready
dmem_busywait_i  input  1  data memory not ready
load_stall_i  input  1  load-use hazard from hazard detection unit
branch_taken_ex_i  input  1  taken branch/jump resolved in EX (1-cycle pulse)
mc_start_i  input  1  multi-cycle op entering EX (1-cycle pulse)
mc_done_i  input  1  multi-cycle unit result valid
freeze_o  output  1  global busywait: all pipeline registers hold
stall_if_o  output  1  PC and IF/ID hold
stall_id_o  output  1  ID holds, bubble into ID/EX
flush_if_id_o  output  1  clear IF/ID register
flush_id_ex_o  output  1  clear ID/EX register
redirect_o  output  1  PC mux selects branch target this cycle
mc_abort_o  output  1  1-cycle pulse: watchdog expired, kill multi-cycle op
state_o  output  1  0=RUN, 1=MC_WAIT (debug)

Behaviour:
- Reset (rst_ni low, async): state=RUN, watchdog=0, branch_pending=0; all outputs 0.
- States: RUN, MC_WAIT. branch_pending: 1-bit register.
- freeze_o = imem_busywait_i | dmem_busywait_i | (state==MC_WAIT & !mc_done_i). Combinational, same-cycle.
- br = branch_taken_ex_i | branch_pending.
- When freeze_o=1: flush_*, redirect_o, stall_* all 0. If branch_taken_ex_i=1, set branch_pending.
- When freeze_o=0 and br=1: flush_if_id_o=flush_id_ex_o=redirect_o=1, stall_*=0, branch_pending cleared next edge. Branch overrides load_stall_i (dependent instr is killed).
- When freeze_o=0, br=0, load_stall_i=1: stall_if_o=stall_id_o=1, no flush. Exactly one bubble per load_stall_i cycle.
- RUN -> MC_WAIT: mc_start_i=1 and freeze_o=0 and br=0; watchdog<=0. mc_start_i ignored if br=1 (op squashed) or freeze_o=1 (source holds it).
- MC_WAIT: watchdog increments each cycle. mc_done_i=1 -> RUN next edge; freeze_o deasserts same cycle as mc_done_i (unless memory busywait). watchdog==MC_TIMEOUT-1 without mc_done_i -> mc_abort_o=1 that cycle, RUN next edge.
- mc_done_i and dmem_busywait_i simultaneous in MC_WAIT: go RUN; freeze_o stays 1 via busywait.
- mc_done_i in RUN: ignored.
- Reset mid-MC_WAIT: immediate RUN, pending branch discarded.
- state_o = registered state.

Optional Feature:
PIPE_CTRL_PERF_EN: defined -> adds outputs stall_cycles_o[31:0] (counts cycles with freeze_o|stall_id_o) and flush_count_o[31:0] (counts cycles with redirect_o); both wrap at 2^32, reset to 0 asynchronously. Undefined -> ports and counters absent, no other change.

Test Plan:
load_stall_i=1 for 1 cycle, no other events -> stall_if_o=stall_id_o=1 for exactly that cycle, flush_*=0.
branch_taken_ex_i pulse with load_stall_i=1 same cycle -> flush_if_id_o=flush_id_ex_o=redirect_o=1, stall_*=0.
branch_taken_ex_i pulse while dmem_busywait_i=1 for 3 cycles -> no flush during busywait; flush+redirect on 4th cycle only, branch_pending 0 after.
mc_start_i, mc_done_i 5 cycles later -> state_o=1 for 5 cycles, freeze_o=1 for 4 cycles, 0 on done cycle, RUN after.
mc_start_i, no mc_done_i, MC_TIMEOUT=64 -> mc_abort_o pulses on 64th MC_WAIT cycle, state_o=0 next; rst_ni low mid-MC_WAIT -> state_o=0 and freeze_o=0 immediately.
PIPE_CTRL_PERF_EN: 3 load stalls + 2 branches -> stall_cycles_o=3, flush_count_o=2.
